// File: rtl/input_circuit.sv
// input_circuit: serial-to-parallel front end for the 64-point FFT.
// Collects eight complex samples per group into Q1..Q8, applies the
// real/imaginary interchange for inverse frames, and tracks the group
// position inside a 64-sample frame.
module input_circuit #(
    parameter int W      = 32,
    parameter int GROUPS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] D,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic         mode,
    output logic [W-1:0] Q1,
    output logic [W-1:0] Q2,
    output logic [W-1:0] Q3,
    output logic [W-1:0] Q4,
    output logic [W-1:0] Q5,
    output logic [W-1:0] Q6,
    output logic [W-1:0] Q7,
    output logic [W-1:0] Q8,
    output logic         out_valid,
    output logic [2:0]   out_group,
    output logic         frame_done,
    output logic         sync_err
);

    localparam logic [2:0] LAST_WORD  = 3'd7;
    localparam logic [2:0] LAST_GROUP = 3'(GROUPS - 1);

    // Interchange real and imaginary halves when sw is set.
    function automatic logic [W-1:0] swap_iq(input logic [W-1:0] d, input logic sw);
        logic [W-1:0] r;
        if (sw) begin
            r = {d[W/2-1:0], d[W-1:W/2]};
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [2:0]   wcnt_r;
    logic [2:0]   gcnt_r;
    logic         mode_q_r;
    logic [W-1:0] stage_r [0:6];
    logic [W-1:0] q_r [0:7];
    logic         out_valid_r;
    logic [2:0]   out_group_r;
    logic         frame_done_r;
    logic         sync_err_r;

    logic         latch_s;
    logic         eff_mode_s;
    logic [W-1:0] word_s;
    logic         at_start_s;

    // Decide which mode applies to the incoming word and form the stored value.
    always_comb begin
        at_start_s = 1'b0;
        latch_s    = 1'b0;
        eff_mode_s = mode_q_r;
        if ((wcnt_r == 3'd0) && (gcnt_r == 3'd0)) begin
            at_start_s = 1'b1;
        end else begin
            at_start_s = 1'b0;
        end
        if (in_valid && (in_sof || at_start_s)) begin
            latch_s    = 1'b1;
            eff_mode_s = mode;
        end else begin
            latch_s    = 1'b0;
            eff_mode_s = mode_q_r;
        end
        word_s = swap_iq(D, eff_mode_s);
    end

    // Counters, staging, output group registers and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_r       <= 3'd0;
            gcnt_r       <= 3'd0;
            mode_q_r     <= 1'b0;
            out_valid_r  <= 1'b0;
            out_group_r  <= 3'd0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
            for (int i = 0; i < 8; i++) begin
                q_r[i] <= {W{1'b0}};
            end
        end else begin
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            if (in_valid) begin
                if (latch_s) begin
                    mode_q_r <= mode;
                end
                if (in_sof) begin
                    // Resynchronise: this word opens group 0, partial data is dropped.
                    stage_r[0] <= word_s;
                    wcnt_r     <= 3'd1;
                    gcnt_r     <= 3'd0;
                    sync_err_r <= !at_start_s;
                end else if (wcnt_r == LAST_WORD) begin
                    for (int i = 0; i < 7; i++) begin
                        q_r[i] <= stage_r[i];
                    end
                    q_r[7]       <= word_s;
                    out_valid_r  <= 1'b1;
                    out_group_r  <= gcnt_r;
                    frame_done_r <= (gcnt_r == LAST_GROUP);
                    wcnt_r       <= 3'd0;
                    gcnt_r       <= (gcnt_r == LAST_GROUP) ? 3'd0 : gcnt_r + 3'd1;
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        if (wcnt_r == 3'(i)) begin
                            stage_r[i] <= word_s;
                        end
                    end
                    wcnt_r <= wcnt_r + 3'd1;
                end
            end
        end
    end

    assign Q1         = q_r[0];
    assign Q2         = q_r[1];
    assign Q3         = q_r[2];
    assign Q4         = q_r[3];
    assign Q5         = q_r[4];
    assign Q6         = q_r[5];
    assign Q7         = q_r[6];
    assign Q8         = q_r[7];
    assign out_valid  = out_valid_r;
    assign out_group  = out_group_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_input_circuit.sv
// Directed testbench for input_circuit.
module tb_input_circuit;

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic        in_valid;
    logic        in_sof;
    logic        mode;
    logic [31:0] q [0:7];
    logic        out_valid;
    logic [2:0]  out_group;
    logic        frame_done;
    logic        sync_err;

    int checks = 0;
    int errors = 0;

    input_circuit #(.W(32), .GROUPS(8)) dut (
        .clk(clk), .rst(rst), .D(d), .in_valid(in_valid), .in_sof(in_sof), .mode(mode),
        .Q1(q[0]), .Q2(q[1]), .Q3(q[2]), .Q4(q[3]),
        .Q5(q[4]), .Q6(q[5]), .Q7(q[6]), .Q8(q[7]),
        .out_valid(out_valid), .out_group(out_group),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic push(input logic v, input logic s, input logic m, input logic [31:0] val);
        in_valid = v;
        in_sof   = s;
        mode     = m;
        d        = val;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic ov, input logic [2:0] grp,
                              input logic fd, input logic se);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".out_group"}, {29'd0, out_group}, {29'd0, grp});
        check({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, fd});
        check({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, se});
    endtask

    // Q(i+1) expected to equal base + step*i.
    task automatic check_q(input string tag, input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.Q%0d", tag, i + 1), q[i], base + step * 32'(i));
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; mode = 1'b0; d = 32'd0;
        @(posedge clk); #1;
        push(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check_ctrl("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check_q("reset", 32'd0, 32'd0);
        rst = 1'b1;

        // Full frame of 64 continuous words D=k, forward mode.
        for (int k = 0; k < 64; k++) begin
            push(1'b1, (k == 0), 1'b0, 32'(k));
            if ((k % 8) == 7) begin
                check_ctrl($sformatf("frame.g%0d", k / 8), 1'b1, 3'(k / 8), (k == 63), 1'b0);
                check_q($sformatf("frame.g%0d", k / 8), 32'(k - 7), 32'd1);
            end else begin
                check($sformatf("frame.k%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
                check($sformatf("frame.k%0d.frame_done", k), {31'd0, frame_done}, 32'd0);
            end
        end
        push(1'b0, 1'b0, 1'b0, 32'd0);
        check_ctrl("idle", 1'b0, 3'd7, 1'b0, 1'b0);
        check_q("idle.hold", 32'd56, 32'd1);

        // Inverse frame: mode latched on sof, dropping mode later has no effect.
        for (int k = 0; k < 8; k++) begin
            push(1'b1, (k == 0), 1'b1, 32'h1234_ABCD);
        end
        check_ctrl("inv.g0", 1'b1, 3'd0, 1'b0, 1'b0);
        check_q("inv.g0", 32'hABCD_1234, 32'd0);
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h1234_ABCD);
        end
        check_ctrl("inv.g1", 1'b1, 3'd1, 1'b0, 1'b0);
        check_q("inv.g1", 32'hABCD_1234, 32'd0);
        // New sof (mid-frame at group 2 word 0) relatches forward mode.
        push(1'b1, 1'b1, 1'b0, 32'h1234_ABCD);
        check_ctrl("fwd.sof", 1'b0, 3'd1, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h1234_ABCD);
        end
        check_ctrl("fwd.g0", 1'b1, 3'd0, 1'b0, 1'b0);
        check_q("fwd.g0", 32'h1234_ABCD, 32'd0);

        // Gapped group: three idle cycles between words (state is at group 1).
        for (int k = 0; k < 8; k++) begin
            push(1'b1, (k == 0), 1'b0, 32'h100 + 32'(k));
            if (k == 0) begin
                check("gap.sync_err", {31'd0, sync_err}, 32'd1);
            end
            if (k < 7) begin
                for (int g = 0; g < 3; g++) begin
                    push(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
                    check($sformatf("gap.k%0d.%0d.out_valid", k, g), {31'd0, out_valid}, 32'd0);
                end
            end
        end
        check_ctrl("gap", 1'b1, 3'd0, 1'b0, 1'b0);
        check_q("gap", 32'h100, 32'd1);
        push(1'b0, 1'b0, 1'b0, 32'd0);
        check("gap.pulse_end", {31'd0, out_valid}, 32'd0);

        // Reach group 2 then assert sof on word 5.
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h400 + 32'(k));
        end
        check_ctrl("pre.g1", 1'b1, 3'd1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h450 + 32'(k));
            check($sformatf("partial.k%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
        end
        push(1'b1, 1'b1, 1'b0, 32'h500);
        check_ctrl("midsof", 1'b0, 3'd1, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h500 + 32'(k));
            if (k < 7) begin
                check($sformatf("resync.k%0d.sync_err", k), {31'd0, sync_err}, 32'd0);
                check($sformatf("resync.k%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
            end
        end
        check_ctrl("resync", 1'b1, 3'd0, 1'b0, 1'b0);
        check_q("resync", 32'h500, 32'd1);

        // Reset after four words of group 1.
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h600 + 32'(k));
        end
        rst = 1'b0;
        push(1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
        check_ctrl("rst_mid.a", 1'b0, 3'd0, 1'b0, 1'b0);
        check_q("rst_mid.a", 32'd0, 32'd0);
        push(1'b1, 1'b0, 1'b0, 32'hDEAD_0001);
        check_ctrl("rst_mid.b", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h700 + 32'(k));
            if (k < 7) begin
                check($sformatf("post_rst.k%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
            end
        end
        check_ctrl("post_rst", 1'b1, 3'd0, 1'b0, 1'b0);
        check_q("post_rst", 32'h700, 32'd1);

        // Reset coincident with the 8th word.
        for (int k = 0; k < 7; k++) begin
            push(1'b1, 1'b0, 1'b0, 32'h800 + 32'(k));
        end
        rst = 1'b0;
        push(1'b1, 1'b0, 1'b0, 32'h807);
        check_ctrl("rst_8th", 1'b0, 3'd0, 1'b0, 1'b0);
        check_q("rst_8th", 32'd0, 32'd0);
        rst = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'd0);
        check_ctrl("rst_8th.after", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_circuit.md
# input_circuit

Front-end deserializer for the 64-point FFT processor: it accepts one 32-bit complex sample per valid cycle and assembles each run of 8 samples into a parallel group of eight words (Q1..Q8) for the first butterfly stage. It is the receive-side counterpart of the output shift chain. It applies the real/imaginary interchange on entry when the frame is an inverse transform, and it tracks position within the 64-sample frame (8 groups of 8).

## Interface

Parameters:
- W, 32, sample width; [W-1:W/2] real, [W/2-1:0] imaginary, two's complement.
- GROUPS, 8, groups per frame (64 points / 8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-low (rst=0 at a rising edge of clk resets the block).
- D  in  W  serial input sample.
- in_valid  in  1  D is valid this cycle; accepted unconditionally (no backpressure).
- in_sof  in  1  start of frame; only meaningful when in_valid=1; marks D as word 0 of group 0.
- mode  in  1  0 = forward FFT, 1 = inverse (swap real/imag); latched per frame.
- Q1..Q8  out  W  assembled group; Q1 = first word received, Q8 = eighth.
- out_valid  out  1  one-cycle pulse; Q1..Q8 hold a new group.
- out_group  out  3  index of the group presented on Q1..Q8 (0..7).
- frame_done  out  1  pulses with out_valid when out_group=7.
- sync_err  out  1  one-cycle pulse; in_sof arrived mid-frame.

## Operation

- State: word counter wcnt (0..7), group counter gcnt (0..GROUPS-1), staging registers S0..S6, frame mode register mode_q, output registers Q1..Q8.
- Mode latch: on an accepted word with (in_sof=1) or (wcnt=0 and gcnt=0), mode_q is loaded with mode. That word is swapped using the live mode value. All later words in the frame use mode_q.
- Swap: when the effective mode is 1, the stored word is {D[W/2-1:0], D[W-1:W/2]}; otherwise D is stored unchanged. There is no scaling on input.
- Accept (in_valid=1, wcnt<7): S[wcnt] is loaded with the swapped D, then wcnt increments.
- Accept with wcnt=7: Q1..Q7 are loaded with S0..S6 and Q8 with the swapped D. out_valid=1 and out_group=gcnt are set for the next cycle. wcnt wraps to 0. gcnt increments and wraps from GROUPS-1 to 0. frame_done=1 if gcnt was GROUPS-1.
- in_sof with in_valid:
  - D is treated as word 0 of group 0: it is stored in S0, wcnt becomes 1, gcnt becomes 0.
  - Any partial group is discarded, and Q1..Q8 are unchanged.
  - If (wcnt,gcnt) was not (0,0) beforehand, sync_err pulses the next cycle.
- in_sof with in_valid=0 is ignored.
- in_valid=0: all state holds; out_valid, frame_done and sync_err return to 0.
- Q1..Q8 change only when out_valid is asserted, and stay stable until the next group completes.

## Timing

- Reset values:
  - Outputs: Q1..Q8=0, out_valid=0, out_group=0, frame_done=0, sync_err=0.
  - Internal state: wcnt=0, gcnt=0, mode_q=0, S0..S6=0.
- Reset wins over in_valid in the same cycle. Reset mid-group discards the partial data, and the next accepted word is word 0 of group 0.
- Latency: the 8th word is accepted at edge N, and out_valid, Q1..Q8, out_group and frame_done are visible after edge N (one cycle).
- Throughput: one word per cycle sustained. Back-to-back groups produce an out_valid pulse every 8 cycles with no bubbles.
- Gaps: in_valid may deassert for any number of cycles inside a group. Counters and staging registers hold across the gap.
- sync_err is coincident with the cycle after the offending in_sof. It may coincide with nothing else, because that in_sof never completes a group.

## Test plan

- Reset then 64 continuous words with D=k (k=0..63), mode=0, in_sof on k=0:
  - 8 out_valid pulses, 8 cycles apart.
  - Group g has Q1=8g … Q8=8g+7 and out_group=g.
  - frame_done only on g=7, with its Q8=63.
- Frame with mode=1 and D=0x1234ABCD for every word: all Q = 0xABCD1234. Dropping mode to 0 mid-frame does not change the swap until the next in_sof.
- Gapped input: 8 words with in_valid deasserted 3 cycles between each. Exactly one out_valid, Q1..Q8 in order, arriving one cycle after the 8th word.
- in_sof asserted on word 5 of group 2:
  - sync_err pulses once.
  - No out_valid occurs for the partial group.
  - The next 8 words yield out_group=0.
- rst=0 asserted after 4 words of a group, then 8 words applied: outputs read zero during reset. A single group forms from the post-reset words only, with out_group=0.
- rst=0 together with in_valid and the 8th word in the same cycle: no out_valid, and all outputs are 0.
